// File: rtl/pc_unit_ras.sv
// rtl/pc_unit_ras.sv - fetch-stage program counter with branch/jump/trap redirect and circular return-address stack
module pc_unit_ras #(
    parameter int                ADDR_W      = 32,
    parameter int                INSTR_BYTES = 4,
    parameter logic [ADDR_W-1:0] RESET_VALUE = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] TRAP_VECTOR = 32'h0000_0010,
    parameter int                RAS_DEPTH   = 8,
    localparam int               WS          = $clog2(INSTR_BYTES),
    localparam int               PW          = $clog2(RAS_DEPTH),
    localparam int               CW          = PW + 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 stall,
    input  logic [2:0]           ps,
    input  logic [ADDR_W-WS-1:0] in,
    output logic [ADDR_W-1:0]    pc,
    output logic [CW-1:0]        ras_count,
    output logic                 ras_overflow,
    output logic                 ras_underflow
);

    typedef enum logic [2:0] {
        PS_HOLD = 3'b000,
        PS_INC  = 3'b001,
        PS_BR   = 3'b010,
        PS_JMP  = 3'b011,
        PS_CALL = 3'b100,
        PS_RET  = 3'b101,
        PS_TRAP = 3'b110,
        PS_RSVD = 3'b111
    } ps_t;

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]     ras_ptr;

    logic [ADDR_W-1:0] npc;
    logic [ADDR_W-1:0] off;
    logic [ADDR_W-1:0] abs_addr;
    logic [ADDR_W-1:0] ras_top;
    logic [PW-1:0]     ptr_dec;
    logic              ras_full;
    logic              ras_empty;

    logic [ADDR_W-1:0] pc_nxt;
    logic [PW-1:0]     ptr_nxt;
    logic [CW-1:0]     count_nxt;
    logic              push;
    logic              overflow_nxt;
    logic              underflow_nxt;

    // Candidate targets: sequential, signed word offset, absolute word address, stack top
    always_comb begin
        npc       = pc + ADDR_W'(INSTR_BYTES);
        off       = ADDR_W'($signed(in)) << WS;
        abs_addr  = ADDR_W'(in) << WS;
        ptr_dec   = ras_ptr - 1'b1;
        ras_top   = ras_mem[ptr_dec];
        ras_full  = (ras_count == CW'(RAS_DEPTH));
        ras_empty = (ras_count == '0);
    end

    // Next-PC selection and stack bookkeeping; a stall leaves everything as is
    always_comb begin
        pc_nxt        = pc;
        ptr_nxt       = ras_ptr;
        count_nxt     = ras_count;
        push          = 1'b0;
        overflow_nxt  = 1'b0;
        underflow_nxt = 1'b0;
        if (!stall) begin
            case (ps_t'(ps))
                PS_INC:  pc_nxt = npc;
                PS_BR:   pc_nxt = npc + off;
                PS_JMP:  pc_nxt = abs_addr;
                PS_CALL: begin
                    pc_nxt  = npc + off;
                    push    = 1'b1;
                    ptr_nxt = ras_ptr + 1'b1;
                    // A full stack wraps onto its oldest entry rather than refusing the call
                    if (ras_full) begin
                        overflow_nxt = 1'b1;
                    end else begin
                        count_nxt = ras_count + 1'b1;
                    end
                end
                PS_RET: begin
                    // The top entry is only consumed when the stack holds something
                    if (!ras_empty) begin
                        pc_nxt    = ras_top;
                        ptr_nxt   = ptr_dec;
                        count_nxt = ras_count - 1'b1;
                    end else begin
                        pc_nxt        = TRAP_VECTOR;
                        underflow_nxt = 1'b1;
                    end
                end
                PS_TRAP: pc_nxt = TRAP_VECTOR;
                default: pc_nxt = pc;
            endcase
        end
    end

    // PC, stack pointer, occupancy and event pulses
    always_ff @(posedge clock) begin
        if (!reset) begin
            pc            <= RESET_VALUE;
            ras_ptr       <= '0;
            ras_count     <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            pc            <= pc_nxt;
            ras_ptr       <= ptr_nxt;
            ras_count     <= count_nxt;
            ras_overflow  <= overflow_nxt;
            ras_underflow <= underflow_nxt;
        end
    end

    // Stack storage needs no reset; occupancy guards every read
    always_ff @(posedge clock) begin
        if (reset && push) begin
            ras_mem[ras_ptr] <= npc;
        end
    end

endmodule

// File: tb/tb_pc_unit_ras.sv
// tb/tb_pc_unit_ras.sv - directed table-driven bench for pc_unit_ras
module tb_pc_unit_ras;

    localparam int ADDR_W = 32;
    localparam int IW     = 30;
    localparam logic [31:0] RV = 32'h0000_0100;
    localparam logic [31:0] TV = 32'h0000_0010;

    logic          clock = 1'b0;
    logic          reset;
    logic          stall;
    logic [2:0]    ps;
    logic [IW-1:0] in;
    logic [31:0]   pc;
    logic [3:0]    ras_count;
    logic          ras_overflow;
    logic          ras_underflow;

    int errors = 0;
    int checks = 0;

    pc_unit_ras #(
        .ADDR_W(ADDR_W),
        .INSTR_BYTES(4),
        .RESET_VALUE(RV),
        .TRAP_VECTOR(TV),
        .RAS_DEPTH(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .stall(stall),
        .ps(ps),
        .in(in),
        .pc(pc),
        .ras_count(ras_count),
        .ras_overflow(ras_overflow),
        .ras_underflow(ras_underflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          stall;
        logic [2:0]    ps;
        logic [IW-1:0] in;
        logic [31:0]   pc;
        logic [3:0]    cnt;
        logic          ovf;
        logic          unf;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic [2:0] p, input logic [IW-1:0] i);
        stall = s;
        ps    = p;
        in    = i;
        @(posedge clock);
        #1;
    endtask

    task automatic expect_all(input string tag, input logic [31:0] epc, input logic [3:0] ecnt,
                              input logic eovf, input logic eunf);
        check({tag, " pc"}, pc, epc);
        check({tag, " ras_count"}, {28'd0, ras_count}, {28'd0, ecnt});
        check({tag, " ras_overflow"}, {31'd0, ras_overflow}, {31'd0, eovf});
        check({tag, " ras_underflow"}, {31'd0, ras_underflow}, {31'd0, eunf});
    endtask

    initial begin
        //            stall ps      in              pc            cnt ovf unf
        vecs[0]  = '{1'b0, 3'b001, 30'd0,          32'h0000_0104, 4'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 3'b001, 30'd0,          32'h0000_0108, 4'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 3'b001, 30'd0,          32'h0000_010C, 4'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 3'b010, 30'h3FFF_FFFE,  32'h0000_0108, 4'd0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 3'b011, 30'h40,         32'h0000_0100, 4'd0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 3'b011, 30'h42,         32'h0000_0108, 4'd0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 3'b100, 30'd4,          32'h0000_011C, 4'd1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 3'b101, 30'd0,          32'h0000_010C, 4'd0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 3'b101, 30'd0,          TV,            4'd0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 3'b000, 30'd0,          TV,            4'd0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 3'b011, 30'h3FFF_FFFF,  32'hFFFF_FFFC, 4'd0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 3'b001, 30'd0,          32'h0000_0000, 4'd0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 3'b100, 30'd1,          32'h0000_0008, 4'd1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 3'b110, 30'd5,          TV,            4'd1, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 3'b111, 30'd7,          TV,            4'd1, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 3'b001, 30'd0,          TV,            4'd1, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 3'b101, 30'd0,          32'h0000_0004, 4'd0, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 3'b010, 30'h3FFF_FFFD,  32'hFFFF_FFFC, 4'd0, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 3'b010, 30'd1,          32'h0000_0004, 4'd0, 1'b0, 1'b0};

        // Reset held two cycles with stall and INC requested
        reset = 1'b0;
        stall = 1'b1;
        ps    = 3'b001;
        in    = '0;
        @(posedge clock);
        @(posedge clock);
        #1;
        expect_all("reset", RV, 4'd0, 1'b0, 1'b0);
        reset = 1'b1;

        for (int v = 0; v < 19; v++) begin
            step(vecs[v].stall, vecs[v].ps, vecs[v].in);
            expect_all($sformatf("vec%0d", v), vecs[v].pc, vecs[v].cnt, vecs[v].ovf, vecs[v].unf);
        end

        // Fill the stack past its depth from address 0
        step(1'b0, 3'b011, 30'd0);
        check("jmp0 pc", pc, 32'h0);
        for (int i = 1; i <= 9; i++) begin
            step(1'b0, 3'b100, 30'd0);
            expect_all($sformatf("call%0d", i), 32'(4 * i), (i > 8) ? 4'd8 : 4'(i), (i == 9), 1'b0);
        end
        step(1'b0, 3'b000, 30'd0);
        expect_all("after ovf", 32'h24, 4'd8, 1'b0, 1'b0);
        for (int j = 0; j < 8; j++) begin
            step(1'b0, 3'b101, 30'd0);
            expect_all($sformatf("ret%0d", j), 32'(32'h24 - 4 * j), 4'(7 - j), 1'b0, 1'b0);
        end
        step(1'b0, 3'b101, 30'd0);
        expect_all("ret underflow", TV, 4'd0, 1'b0, 1'b1);
        step(1'b0, 3'b000, 30'd0);
        expect_all("after unf", TV, 4'd0, 1'b0, 1'b0);

        // Stall freezes a pending call, then reset wins over stall
        step(1'b0, 3'b011, 30'h50);
        step(1'b0, 3'b100, 30'd0);
        expect_all("pre-stall call", 32'h144, 4'd1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 3'b100, 30'd3);
            expect_all($sformatf("stall%0d", k), 32'h144, 4'd1, 1'b0, 1'b0);
        end
        reset = 1'b0;
        step(1'b1, 3'b100, 30'd3);
        expect_all("reset under stall", RV, 4'd0, 1'b0, 1'b0);
        reset = 1'b1;
        step(1'b0, 3'b101, 30'd0);
        expect_all("ret after reset", TV, 4'd0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
